// File: rtl/hisoc_test_seq.sv
// Test sequencer for HISOC: loads the instruction ROM, clears data memory, sequences
// core reset/enable, then watches the s10/s11 taps to decide pass, fail or timeout.
module hisoc_test_seq #(
    parameter int unsigned CPU_WIDTH   = 32,
    parameter int unsigned IROM_AW     = 10,
    parameter int unsigned DMEM_AW     = 10,
    parameter int unsigned SETTLE_CYC  = 5,
    parameter int unsigned CHECK_DLY   = 4,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [CPU_WIDTH-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 irom_we,
    output logic [IROM_AW-1:0]   irom_addr,
    output logic [CPU_WIDTH-1:0] irom_wdata,
    output logic                 dmem_we,
    output logic [DMEM_AW-1:0]   dmem_addr,
    output logic [CPU_WIDTH-1:0] dmem_wdata,
    output logic                 core_rst_n,
    output logic                 core_en,
    input  logic [CPU_WIDTH-1:0] end_flag,
    input  logic [CPU_WIDTH-1:0] pass_flag,
    input  logic [CPU_WIDTH-1:0] test_num,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [CPU_WIDTH-1:0] fail_num
);

    localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned DMAX = (SETTLE_CYC > CHECK_DLY) ? SETTLE_CYC : CHECK_DLY;
    localparam int unsigned DW   = (DMAX < 2) ? 1 : $clog2(DMAX + 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StClear, StSettle, StRun, StCheck, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [IROM_AW-1:0]     wcnt_q, wcnt_d;
    logic [DW-1:0]          dly_q, dly_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   irom_we_q, irom_we_d;
    logic [IROM_AW-1:0]     irom_addr_q, irom_addr_d;
    logic [CPU_WIDTH-1:0]   irom_wdata_q, irom_wdata_d;
    logic                   dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0]     dmem_addr_q, dmem_addr_d;
    logic                   core_rst_n_q, core_rst_n_d;
    logic                   core_en_q, core_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic [CPU_WIDTH-1:0]   fail_num_q, fail_num_d;

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        dly_d        = dly_q;
        tmo_d        = tmo_q;
        irom_we_d    = 1'b0;
        irom_addr_d  = irom_addr_q;
        irom_wdata_d = irom_wdata_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        core_rst_n_d = core_rst_n_q;
        core_en_d    = core_en_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_num_d   = fail_num_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StLoad;
                    wcnt_d     = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    fail_num_d = '0;
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    irom_we_d    = 1'b1;
                    irom_addr_d  = wcnt_q;
                    irom_wdata_d = ld_data;
                    wcnt_d       = wcnt_q + 1'b1;
                    // A full ROM ends the load even if ld_last never arrives.
                    if (ld_last || (wcnt_q == '1)) begin
                        state_d     = StClear;
                        dmem_we_d   = 1'b1;
                        dmem_addr_d = '0;
                    end
                end
            end
            StClear: begin
                if (dmem_addr_q == '1) begin
                    state_d      = StSettle;
                    dmem_we_d    = 1'b0;
                    core_rst_n_d = 1'b1;
                    dly_d        = '0;
                end else begin
                    dmem_addr_d = dmem_addr_q + 1'b1;
                end
            end
            StSettle: begin
                if (dly_q == DW'(SETTLE_CYC - 1)) begin
                    state_d   = StRun;
                    core_en_d = 1'b1;
                    tmo_d     = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            StRun: begin
                tmo_d = tmo_q + 1'b1;
                // End-of-test takes priority over a coincident timeout.
                if (end_flag == CPU_WIDTH'(1)) begin
                    state_d = StCheck;
                    dly_d   = '0;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d      = StDone;
                    done_d       = 1'b1;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b1;
                    core_en_d    = 1'b0;
                    core_rst_n_d = 1'b0;
                end
            end
            StCheck: begin
                if (dly_q == DW'(CHECK_DLY - 1)) begin
                    state_d      = StDone;
                    done_d       = 1'b1;
                    core_en_d    = 1'b0;
                    core_rst_n_d = 1'b0;
                    if (pass_flag == CPU_WIDTH'(1)) begin
                        pass_d = 1'b1;
                    end else begin
                        pass_d     = 1'b0;
                        fail_num_d = test_num;
                    end
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle) && (state_d != StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            dly_q        <= '0;
            tmo_q        <= '0;
            irom_we_q    <= 1'b0;
            irom_addr_q  <= '0;
            irom_wdata_q <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            core_rst_n_q <= 1'b0;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            dly_q        <= dly_d;
            tmo_q        <= tmo_d;
            irom_we_q    <= irom_we_d;
            irom_addr_q  <= irom_addr_d;
            irom_wdata_q <= irom_wdata_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            core_rst_n_q <= core_rst_n_d;
            core_en_q    <= core_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_num_q   <= fail_num_d;
        end
    end

    assign ld_ready   = (state_q == StLoad);
    assign irom_we    = irom_we_q;
    assign irom_addr  = irom_addr_q;
    assign irom_wdata = irom_wdata_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = '0;
    assign core_rst_n = core_rst_n_q;
    assign core_en    = core_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign fail_num   = fail_num_q;

endmodule

// File: tb/tb_hisoc_test_seq.sv
// Directed bench for hisoc_test_seq: load, clear, settle, pass/fail/timeout and boundaries.
module tb_hisoc_test_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        irom_we;
    logic [9:0]  irom_addr;
    logic [31:0] irom_wdata;
    logic        dmem_we;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        core_rst_n, core_en;
    logic [31:0] end_flag = '0;
    logic [31:0] pass_flag = '0;
    logic [31:0] test_num = '0;
    logic        busy, done, pass, timeout;
    logic [31:0] fail_num;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hisoc_test_seq #(
        .CPU_WIDTH(32), .IROM_AW(10), .DMEM_AW(10),
        .SETTLE_CYC(5), .CHECK_DLY(4), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .irom_we(irom_we), .irom_addr(irom_addr), .irom_wdata(irom_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .core_rst_n(core_rst_n), .core_en(core_en),
        .end_flag(end_flag), .pass_flag(pass_flag), .test_num(test_num),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .fail_num(fail_num)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run();
        int k = 0;
        while (!core_en && k < 3000) begin
            tick();
            k++;
        end
        checks++;
        if (!core_en) begin
            errors++;
            $display("FAIL wait_run core_en got %0b want 1 after %0d cycles", core_en, k);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({core_rst_n, core_en, busy, done, pass, timeout, irom_we, dmem_we, ld_ready} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", {core_rst_n, core_en, busy, done, pass,
                     timeout, irom_we, dmem_we, ld_ready});
        end
        checks++;
        if (fail_num !== 32'd0 || irom_addr !== 10'd0 || dmem_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_values got %0h/%0h/%0h want 0", fail_num, irom_addr, dmem_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_cont();
        int n = 0;
        int bad = 0;
        int k = 0;
        pulse_start();
        checks++;
        if (ld_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_ready got %b%b want 11", ld_ready, busy);
        end
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hA000_0000 + i;
            ld_last  = (i == 2);
            tick();
            checks++;
            if (irom_we !== 1'b1 || irom_addr !== 10'(i) || irom_wdata !== 32'hA000_0000 + i) begin
                errors++;
                $display("FAIL load_word%0d got we=%b a=%0d d=%0h want we=1 a=%0d d=%0h", i,
                         irom_we, irom_addr, irom_wdata, i, 32'hA000_0000 + i);
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready_drop got %b want 0", ld_ready);
        end
        while (dmem_we && n < 2000) begin
            if (dmem_addr !== n[9:0] || dmem_wdata !== 32'd0) bad++;
            n++;
            tick();
        end
        checks++;
        if (n != 1024 || bad != 0) begin
            errors++;
            $display("FAIL clear_sweep got %0d writes %0d bad want 1024 writes 0 bad", n, bad);
        end
        checks++;
        if (core_rst_n !== 1'b1 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL settle_entry got rst=%b en=%b want rst=1 en=0", core_rst_n, core_en);
        end
        while (!core_en && k < 20) begin
            tick();
            k++;
        end
        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL settle_len got %0d want 5", k);
        end
    endtask

    task automatic test_pass();
        int k = 0;
        end_flag  = 32'd1;
        pass_flag = 32'd1;
        do begin
            tick();
            k++;
        end while (!done && k < 20);
        end_flag  = 32'd0;
        pass_flag = 32'd0;
        checks++;
        if (k != 5) begin
            errors++;
            $display("FAIL pass_latency got %0d want 5", k);
        end
        checks++;
        if ({done, pass, timeout, core_en, core_rst_n, busy} !== 6'b110000 || fail_num !== 32'd0) begin
            errors++;
            $display("FAIL pass_result got %b fn=%0d want 110000 fn=0",
                     {done, pass, timeout, core_en, core_rst_n, busy}, fail_num);
        end
    endtask

    task automatic test_load_gapped();
        logic [4:0] vv;
        int exp_a = 0;
        vv = 5'b11001;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            ld_valid = vv[i];
            ld_data  = 32'hB000_0000 + i;
            ld_last  = (i == 4);
            tick();
            checks++;
            if (vv[i]) begin
                if (irom_we !== 1'b1 || irom_addr !== 10'(exp_a)) begin
                    errors++;
                    $display("FAIL gap_write%0d got we=%b a=%0d want we=1 a=%0d", i, irom_we,
                             irom_addr, exp_a);
                end
                exp_a++;
            end else if (irom_we !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle%0d got we=%b want 0", i, irom_we);
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        checks++;
        if (ld_ready !== 1'b0 || dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL gap_to_clear got rdy=%b dwe=%b want 0 1", ld_ready, dmem_we);
        end
        wait_run();
    endtask

    task automatic test_fail();
        int k = 0;
        end_flag  = 32'd1;
        pass_flag = 32'd0;
        test_num  = 32'd7;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        end_flag = 32'd0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0 || fail_num !== 32'd7) begin
            errors++;
            $display("FAIL fail_result got d=%b p=%b t=%b fn=%0d want 1 0 0 7", done, pass,
                     timeout, fail_num);
        end
    endtask

    task automatic test_start_ignored();
        int k = 0;
        pulse_start();
        checks++;
        if (done !== 1'b0 || fail_num !== 32'd0 || ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL restart_clear got d=%b fn=%0d rdy=%b want 0 0 1", done, fail_num,
                     ld_ready);
        end
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        wait_run();
        tick();
        pulse_start();
        tick();
        checks++;
        if (core_en !== 1'b1 || busy !== 1'b1 || ld_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run got en=%b busy=%b rdy=%b done=%b want 1 1 0 0", core_en,
                     busy, ld_ready, done);
        end
        end_flag  = 32'd1;
        pass_flag = 32'd1;
        while (!done && k < 20) begin
            tick();
            k++;
        end
        end_flag  = 32'd0;
        pass_flag = 32'd0;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run_end got d=%b p=%b want 1 1", done, pass);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        pulse_start();
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        wait_run();
        while (!done && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (k != 50) begin
            errors++;
            $display("FAIL timeout_len got %0d want 50", k);
        end
        checks++;
        if (timeout !== 1'b1 || pass !== 1'b0 || fail_num !== 32'd0 || core_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result got t=%b p=%b fn=%0d en=%b want 1 0 0 0", timeout,
                     pass, fail_num, core_en);
        end
    endtask

    task automatic test_overflow();
        int writes = 0;
        logic [9:0] last_a = '0;
        pulse_start();
        for (int i = 0; i < 1025; i++) begin
            ld_valid = 1'b1;
            ld_data  = i;
            tick();
            if (irom_we) begin
                writes++;
                last_a = irom_addr;
            end
        end
        ld_valid = 1'b0;
        checks++;
        if (writes != 1024 || last_a !== 10'd1023) begin
            errors++;
            $display("FAIL overflow_writes got %0d last=%0d want 1024 last=1023", writes, last_a);
        end
        checks++;
        if (ld_ready !== 1'b0 || dmem_we !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overflow_clear got rdy=%b dwe=%b busy=%b want 0 1 1", ld_ready,
                     dmem_we, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_we, busy, core_rst_n, core_en, ld_ready, irom_we} !== 6'b0 ||
            dmem_addr !== 10'd0 || irom_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid_clear got %b da=%0d ia=%0d want 0 0 0",
                     {dmem_we, busy, core_rst_n, core_en, ld_ready, irom_we}, dmem_addr, irom_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_cont();
        test_pass();
        test_load_gapped();
        test_fail();
        test_start_ignored();
        test_timeout();
        test_overflow();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
